meter_sequencer: RTL
====================

# meter_sequencer

Periodic sample scheduler and averager for the `meter` measurement datapath. It issues `start` to `meter` at a fixed sample rate, completes the start/busy handshake, and captures `data_v`, `data_i` and `data_p`. Every 2^LOG2_N samples it publishes block averages and adds the block's power sum into an energy accumulator. It sits between `meter` and the register/readout logic and flags overrun and handshake timeouts.

## Interface
- SAMPLE_DIV, 1000: clk cycles between sample ticks; must be ≥ 4.
- LOG2_N, 4: log2 of samples per averaging block, range 0..8.
- START_TIMEOUT, 16: max cycles in START waiting for `meter_busy` to rise.
- BUSY_TIMEOUT, 4096: max cycles in WAIT_DONE waiting for `meter_busy` to fall.
- ENERGY_W, 48: width of the energy accumulator.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  run sampling.
- clr_energy  in  1  single-cycle pulse; zeroes `energy` and `energy_ovf`.
- meter_start  out  1  start request to `meter`.
- meter_busy  in  1  `meter` busy.
- meter_data_v  in  22  voltage sample, signed.
- meter_data_i  in  22  current sample, signed.
- meter_data_p  in  36  power sample, signed.
- avg_v  out  22  block mean voltage, signed.
- avg_i  out  22  block mean current, signed.
- avg_p  out  36  block mean power, signed.
- energy  out  ENERGY_W  running sum of all published block power sums, signed.
- result_valid  out  1  one-cycle pulse when the `avg_*` and `energy` outputs update.
- overrun  out  1  sticky; set when a tick is dropped. Cleared by reset or an `enable` rising edge.
- err_timeout  out  1  sticky; set on either timeout. Same clear rule as `overrun`.
- energy_ovf  out  1  sticky; set on signed overflow of `energy`.

## Operation
- Tick timer:
  - The counter runs 0..SAMPLE_DIV-1 while `enable` is high. `tick` fires when the count equals SAMPLE_DIV-1.
  - When `enable` is low, the counter is held at 0.
- FSM states:
  - IDLE: on `tick`, go to START.
  - START: `meter_start` = 1.
    - `meter_busy` = 1 → go to WAIT_DONE.
    - `START_TIMEOUT` cycles elapse first → set `err_timeout`, go to IDLE.
  - WAIT_DONE: `meter_start` = 0.
    - `meter_busy` = 0 → go to ACCUM.
    - `BUSY_TIMEOUT` cycles elapse first → set `err_timeout`, go to IDLE.
  - ACCUM: add the three data inputs, sampled this cycle, into the sums and increment `sample_cnt`.
    - `sample_cnt` reaches 2^LOG2_N → go to PUBLISH.
    - Otherwise → go to IDLE.
  - PUBLISH: update the `avg_*` outputs, `energy` += `sum_p`, pulse `result_valid`, clear the sums and `sample_cnt`, go to IDLE.
- Timed-out samples are not accumulated. The partial block is kept.
- Arithmetic:
  - `sum_v` and `sum_i` are 22+LOG2_N bits; `sum_p` is 36+LOG2_N bits, all signed, so they cannot overflow.
  - `avg_x` = `sum_x` >>> LOG2_N (arithmetic shift, rounds toward −inf).
  - `energy` adds the sign-extended `sum_p` and wraps on overflow; signed overflow sets `energy_ovf`.
- Overrun: a `tick` arriving in any state other than IDLE is dropped and sets `overrun`. The FSM does not queue ticks.
- `enable` falling:
  - An in-flight conversion completes through ACCUM.
  - On entry to IDLE with `enable` low, the partial sums and `sample_cnt` are cleared.
  - PUBLISH does not occur for a partial block.
- `clr_energy` coinciding with PUBLISH: `energy` loads the sign-extended `sum_p` (the clear applies first), and `energy_ovf` is cleared.

## Timing
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE.
  - Counters and sums are 0.
- Tick at cycle T (FSM in IDLE) → `meter_start` = 1 from T+1.
- `meter_busy` sampled high at edge E → `meter_start` = 0 from E+1.
- `meter_busy` sampled low in WAIT_DONE at cycle D → data sampled in ACCUM at D+1.
- Last sample of a block accumulated at cycle A → `result_valid` is high during A+1, with the new outputs visible in the same cycle.
- `rst` asserted mid-operation: the FSM returns to IDLE and `meter_start` drops immediately (asynchronous). `meter` is expected to be reset by the same `rst`.

## Structure
- Package `meter_pkg` holds:
  - FSM state enum (IDLE, START, WAIT_DONE, ACCUM, PUBLISH).
  - Width constants V_W=22, I_W=22, P_W=36.
- Sub-module `tick_gen` (parameter SAMPLE_DIV; ports clk, rst, enable, tick) implements the timer. Everything else is in one module.

## Test plan
Bench is a behavioural `meter` model: busy rises 2 cycles after start, stays high 50 cycles. Default parameters are SAMPLE_DIV=100, LOG2_N=2.
- Basic averaging: v = 1000, 2000, 3000, 4000 and i = −8 ×4 → one `result_valid`; `avg_v` = 2500, `avg_i` = −8. Consecutive `meter_start` rising edges are exactly 100 cycles apart.
- Rounding and energy: p = 10, 10, 10, 11 for two blocks → `avg_p` = 10 (41>>2) per block, `energy` = 82. After `clr_energy`, `energy` = 0.
- Overrun: model busy width 150 cycles → `overrun` = 1, one in every two ticks is dropped, and averaging continues correctly.
- Timeout: model never raises busy, START_TIMEOUT=16 → `err_timeout` = 1 exactly 16 cycles after `meter_start` rises. FSM returns to IDLE and no sample is accumulated.
- Enable/reset mid-operation:
  - Drop `enable` after 3 samples, re-enable → the next `result_valid` comes only after 4 fresh samples.
  - Assert `rst` in WAIT_DONE → all outputs are 0 immediately.
- Energy overflow: ENERGY_W=40, p = 2^35−1 repeated → `energy_ovf` is set on the first signed wrap.

Source files
------------

// File: rtl/meter_pkg.sv
// Shared types and sample widths for the meter sequencing datapath.
package meter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_DONE,
    ACCUM,
    PUBLISH
  } state_t;

  localparam int V_W = 22;
  localparam int I_W = 22;
  localparam int P_W = 36;

endpackage

// File: rtl/meter_sequencer_tick_gen.sv
// Free-running sample-rate divider; held at zero while sampling is disabled.
module tick_gen #(
  parameter int SAMPLE_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == CNT_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/meter_sequencer.sv
// Schedules meter conversions at a fixed rate, block-averages the samples
// and integrates block power into a wrapping energy accumulator.
module meter_sequencer
  import meter_pkg::*;
#(
  parameter int SAMPLE_DIV    = 1000,
  parameter int LOG2_N        = 4,
  parameter int START_TIMEOUT = 16,
  parameter int BUSY_TIMEOUT  = 4096,
  parameter int ENERGY_W      = 48
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       clr_energy,
  output logic                       meter_start,
  input  logic                       meter_busy,
  input  logic signed [V_W-1:0]      meter_data_v,
  input  logic signed [I_W-1:0]      meter_data_i,
  input  logic signed [P_W-1:0]      meter_data_p,
  output logic signed [V_W-1:0]      avg_v,
  output logic signed [I_W-1:0]      avg_i,
  output logic signed [P_W-1:0]      avg_p,
  output logic signed [ENERGY_W-1:0] energy,
  output logic                       result_valid,
  output logic                       overrun,
  output logic                       err_timeout,
  output logic                       energy_ovf
);

  localparam int SV_W    = V_W + LOG2_N;
  localparam int SI_W    = I_W + LOG2_N;
  localparam int SP_W    = P_W + LOG2_N;
  localparam int TMO_MAX = (START_TIMEOUT > BUSY_TIMEOUT) ? START_TIMEOUT : BUSY_TIMEOUT;
  localparam int TMO_W   = $clog2(TMO_MAX + 1);
  localparam logic [LOG2_N:0] LAST_CNT = (LOG2_N + 1)'((1 << LOG2_N) - 1);

  // Mean of a block: arithmetic shift, so rounding is toward -inf.
  function automatic logic signed [SP_W-1:0] block_mean(input logic signed [SP_W-1:0] s);
    return s >>> LOG2_N;
  endfunction

  function automatic logic add_wraps(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  state_t                     state;
  logic                       tick;
  logic                       enable_d;
  logic [TMO_W-1:0]           tmo_cnt;
  logic [LOG2_N:0]            sample_cnt;
  logic signed [SV_W-1:0]     sum_v, sum_v_nx;
  logic signed [SI_W-1:0]     sum_i, sum_i_nx;
  logic signed [SP_W-1:0]     sum_p, sum_p_nx;
  logic signed [ENERGY_W-1:0] energy_base, energy_add, energy_nx;
  logic                       energy_wrap;
  logic                       last_sample;

  tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  always_comb begin
    sum_v_nx    = sum_v + SV_W'(meter_data_v);
    sum_i_nx    = sum_i + SI_W'(meter_data_i);
    sum_p_nx    = sum_p + SP_W'(meter_data_p);
    last_sample = (sample_cnt == LAST_CNT);
    // A clear landing on the publish update wins first, then the block is added.
    energy_base = clr_energy ? '0 : energy;
    energy_add  = ENERGY_W'(sum_p_nx);
    energy_nx   = energy_base + energy_add;
    energy_wrap = add_wraps(energy_base[ENERGY_W-1], energy_add[ENERGY_W-1],
                            energy_nx[ENERGY_W-1]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      enable_d     <= 1'b0;
      tmo_cnt      <= '0;
      sample_cnt   <= '0;
      sum_v        <= '0;
      sum_i        <= '0;
      sum_p        <= '0;
      meter_start  <= 1'b0;
      avg_v        <= '0;
      avg_i        <= '0;
      avg_p        <= '0;
      energy       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      err_timeout  <= 1'b0;
      energy_ovf   <= 1'b0;
    end else begin
      enable_d     <= enable;
      result_valid <= 1'b0;
      if (enable && !enable_d) begin
        overrun     <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      if (clr_energy) begin
        energy     <= '0;
        energy_ovf <= 1'b0;
      end
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (!enable) begin
            sum_v      <= '0;
            sum_i      <= '0;
            sum_p      <= '0;
            sample_cnt <= '0;
          end
          if (tick) begin
            state       <= START;
            meter_start <= 1'b1;
          end
        end
        START: begin
          if (meter_busy) begin
            state       <= WAIT_DONE;
            meter_start <= 1'b0;
            tmo_cnt     <= '0;
          end else if (tmo_cnt == TMO_W'(START_TIMEOUT - 1)) begin
            state       <= IDLE;
            meter_start <= 1'b0;
            err_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!meter_busy) begin
            state <= ACCUM;
          end else if (tmo_cnt == TMO_W'(BUSY_TIMEOUT - 1)) begin
            state       <= IDLE;
            err_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ACCUM: begin
          sum_v      <= sum_v_nx;
          sum_i      <= sum_i_nx;
          sum_p      <= sum_p_nx;
          sample_cnt <= sample_cnt + 1'b1;
          state      <= IDLE;
          // Outputs are registered here so they appear alongside result_valid in PUBLISH.
          if (last_sample) begin
            avg_v        <= V_W'(block_mean(SP_W'(sum_v_nx)));
            avg_i        <= I_W'(block_mean(SP_W'(sum_i_nx)));
            avg_p        <= P_W'(block_mean(sum_p_nx));
            energy       <= energy_nx;
            energy_ovf   <= (energy_ovf && !clr_energy) || energy_wrap;
            result_valid <= 1'b1;
            state        <= PUBLISH;
          end
        end
        PUBLISH: begin
          sum_v      <= '0;
          sum_i      <= '0;
          sum_p      <= '0;
          sample_cnt <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
